// File: rtl/student_fir_seq.sv
// student_fir_seq: sequential FIR filter peripheral on the student TL-UL bus.
// Software loads coefficients, pushes samples by register write, and the block
// runs one multiply-accumulate per cycle before saturating into RESULT.

package tlul_pkg;
  localparam logic [2:0] PUT_FULL_DATA    = 3'h0;
  localparam logic [2:0] PUT_PARTIAL_DATA = 3'h1;
  localparam logic [2:0] GET              = 3'h4;
  localparam logic [2:0] ACCESS_ACK       = 3'h0;
  localparam logic [2:0] ACCESS_ACK_DATA  = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module student_fir_seq #(
  parameter int NTAPS = 16,
  parameter int DW    = 16,
  parameter int CW    = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  tlul_pkg::tl_h2d_t  tl_i,
  output tlul_pkg::tl_d2h_t  tl_o,
  output logic               irq_o
);

  localparam int IW = $clog2(NTAPS);
  localparam int PW = DW + CW;
  localparam int AW = PW + IW;
  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STATUS = 8'h04;
  localparam logic [7:0] ADDR_SAMPLE = 8'h08;
  localparam logic [7:0] ADDR_RESULT = 8'h0C;
  localparam logic [7:0] COEFF_BASE  = 8'h40;
  localparam int         COEFF_END   = 64 + 4 * NTAPS;
  localparam logic signed [63:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] SAT_MIN = 64'shFFFF_FFFF_8000_0000;

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_DONE} state_e;

  state_e                state_q;
  logic                  en_q, ie_q, done_q, overrun_q;
  logic signed [DW-1:0]  x_q     [NTAPS];
  logic signed [CW-1:0]  coeff_q [NTAPS];
  logic signed [AW-1:0]  acc_q;
  logic [IW-1:0]         idx_q;
  logic [31:0]           result_q;

  logic                  d_valid_q, d_error_q;
  logic [2:0]            d_opcode_q;
  logic [1:0]            d_size_q;
  logic [7:0]            d_source_q;
  logic [31:0]           d_data_q;

  logic                  a_ready, accept, is_get, is_put, busy;
  logic [7:0]            addr, coeff_off;
  logic [IW-1:0]         coeff_idx;
  logic                  hit_ctrl, hit_status, hit_sample, hit_result, hit_coeff;
  logic                  req_err, wr_ok, wr_ctrl, wr_status, wr_sample, wr_coeff;
  logic                  clr, set_overrun;
  logic [31:0]           rdata;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  prod_ext;
  logic signed [63:0]    acc_wide;
  logic [31:0]           acc_sat;
  logic                  unused_bits;

  assign a_ready   = !d_valid_q;
  assign accept    = tl_i.a_valid && a_ready;
  assign busy      = (state_q != ST_IDLE);
  assign addr      = tl_i.a_address[7:0];
  assign coeff_off = addr - COEFF_BASE;
  assign coeff_idx = coeff_off[IW+1:2];
  assign irq_o     = done_q && ie_q;
  assign unused_bits = ^{tl_i.a_param, tl_i.a_mask, tl_i.a_address, tl_i.a_data, coeff_off};

  // Decode the request, classify errors and derive the register write strobes.
  always_comb begin
    is_get      = (tl_i.a_opcode == tlul_pkg::GET);
    is_put      = (tl_i.a_opcode == tlul_pkg::PUT_FULL_DATA) ||
                  (tl_i.a_opcode == tlul_pkg::PUT_PARTIAL_DATA);
    hit_ctrl    = (addr == ADDR_CTRL);
    hit_status  = (addr == ADDR_STATUS);
    hit_sample  = (addr == ADDR_SAMPLE);
    hit_result  = (addr == ADDR_RESULT);
    hit_coeff   = (addr >= COEFF_BASE) && (int'(addr) < COEFF_END) && (addr[1:0] == 2'b00);
    req_err     = !(is_get || is_put) ||
                  !(hit_ctrl || hit_status || hit_sample || hit_result || hit_coeff) ||
                  (is_put && hit_result) ||
                  (is_put && hit_sample && (busy || !en_q)) ||
                  (is_put && hit_coeff && busy);
    set_overrun = accept && is_put && hit_sample && busy;
    wr_ok       = accept && is_put && !req_err;
    wr_ctrl     = wr_ok && hit_ctrl;
    wr_status   = wr_ok && hit_status;
    wr_sample   = wr_ok && hit_sample;
    wr_coeff    = wr_ok && hit_coeff;
    clr         = wr_ctrl && tl_i.a_data[1];
  end

  // Read mux; SAMPLE and unmapped addresses read as zero.
  always_comb begin
    rdata = '0;
    if (hit_ctrl)        rdata = {29'b0, ie_q, 1'b0, en_q};
    else if (hit_status) rdata = {29'b0, overrun_q, done_q, busy};
    else if (hit_result) rdata = result_q;
    else if (hit_coeff)  rdata = {{(32-CW){coeff_q[coeff_idx][CW-1]}}, coeff_q[coeff_idx]};
  end

  // Full-precision product for the current tap and saturation of the running sum.
  always_comb begin
    prod     = x_q[idx_q] * coeff_q[idx_q];
    prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
    acc_wide = {{(64-AW){acc_q[AW-1]}}, acc_q};
    if (acc_wide > SAT_MAX)      acc_sat = 32'h7FFF_FFFF;
    else if (acc_wide < SAT_MIN) acc_sat = 32'h8000_0000;
    else                         acc_sat = acc_wide[31:0];
  end

  // Response channel: capture the answer at accept and hold it until d_ready.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_valid_q  <= 1'b0;
      d_error_q  <= 1'b0;
      d_opcode_q <= '0;
      d_size_q   <= '0;
      d_source_q <= '0;
      d_data_q   <= '0;
    end else if (accept) begin
      d_valid_q  <= 1'b1;
      d_error_q  <= req_err;
      d_opcode_q <= is_get ? tlul_pkg::ACCESS_ACK_DATA : tlul_pkg::ACCESS_ACK;
      d_size_q   <= tl_i.a_size;
      d_source_q <= tl_i.a_source;
      d_data_q   <= (is_get && !req_err) ? rdata : 32'h0;
    end else if (d_valid_q && tl_i.d_ready) begin
      d_valid_q  <= 1'b0;
    end
  end

  always_comb begin
    tl_o          = '0;
    tl_o.d_valid  = d_valid_q;
    tl_o.d_opcode = d_opcode_q;
    tl_o.d_size   = d_size_q;
    tl_o.d_source = d_source_q;
    tl_o.d_data   = d_data_q;
    tl_o.d_error  = d_error_q;
    tl_o.a_ready  = a_ready;
  end

  // CTRL enable bits; clr is a pulse and is never stored.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      en_q <= 1'b0;
      ie_q <= 1'b0;
    end else if (wr_ctrl) begin
      en_q <= tl_i.a_data[0];
      ie_q <= tl_i.a_data[2];
    end
  end

  // Sticky status flags: clr first, then hardware set, then software W1C.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else if (clr) begin
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (state_q == ST_DONE)                   done_q <= 1'b1;
      else if (wr_status && tl_i.a_data[1])     done_q <= 1'b0;
      if (set_overrun)                          overrun_q <= 1'b1;
      else if (wr_status && tl_i.a_data[2])     overrun_q <= 1'b0;
    end
  end

  // Coefficient storage, only writable while the engine is idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NTAPS; k++) coeff_q[k] <= '0;
    end else if (wr_coeff) begin
      coeff_q[coeff_idx] <= tl_i.a_data[CW-1:0];
    end
  end

  // Filter engine: shift in the sample, walk the taps, then saturate into RESULT.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      for (int k = 0; k < NTAPS; k++) x_q[k] <= '0;
    end else if (clr) begin
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
      for (int k = 0; k < NTAPS; k++) x_q[k] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wr_sample) begin
            for (int k = NTAPS - 1; k > 0; k--) x_q[k] <= x_q[k-1];
            x_q[0]  <= tl_i.a_data[DW-1:0];
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc_q <= acc_q + prod_ext;
          idx_q <= idx_q + 1'b1;
          if (idx_q == IW'(NTAPS - 1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          result_q <= acc_sat;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
